// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller.
//   vend_state_e : controller states
//   SEL_*        : item index constants; SEL_CANCEL requests a refund
//   item_price() : price lookup for an item index
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vend_state_e;

  localparam logic [1:0] SEL_ITEM0  = 2'd0;
  localparam logic [1:0] SEL_ITEM1  = 2'd1;
  localparam logic [1:0] SEL_ITEM2  = 2'd2;
  localparam logic [1:0] SEL_CANCEL = 2'd3;

  // The price table is passed in so the top-level parameters stay the
  // single source of truth. Cancel has no price.
  function automatic int unsigned item_price(input logic [1:0] sel,
                                             input int unsigned p0,
                                             input int unsigned p1,
                                             input int unsigned p2);
    case (sel)
      SEL_ITEM0: return p0;
      SEL_ITEM1: return p1;
      SEL_ITEM2: return p2;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_pacer.sv
// Change pacer: after a start pulse, emits `count` one-cycle pulses on
// pulse_o, each followed by one gap cycle (1,0,1,0,...), and raises done_o
// during the final gap cycle. The caller owns any credit bookkeeping.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-low reset
//   start_i   : load count_i; first pulse appears the following cycle
//   count_i   : number of units to pay out
//   pulse_o   : registered change pulse
//   done_o    : high in the last gap cycle of the payout
module vend_change_pacer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             pulse_o,
  output logic             done_o
);

  logic             active_q;
  logic             pulse_q;
  logic [CNT_W-1:0] remain_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q <= 1'b0;
      pulse_q  <= 1'b0;
      remain_q <= '0;
    end else if (start_i) begin
      active_q <= (count_i != '0);
      pulse_q  <= (count_i != '0);
      remain_q <= count_i;
    end else if (active_q) begin
      if (pulse_q) begin
        // Each pulse consumes one unit; the next cycle is its gap.
        pulse_q  <= 1'b0;
        remain_q <= remain_q - CNT_W'(1);
      end else if (remain_q != '0) begin
        pulse_q <= 1'b1;
      end else begin
        active_q <= 1'b0;
      end
    end
  end

  assign pulse_o = pulse_q;
  assign done_o  = active_q && !pulse_q && (remain_q == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: accumulates coin credit, checks a selection against the
// price table, handshakes with the dispenser, then pays change one unit per
// two cycles through vend_change_pacer.
//   clk, reset      : clock (rising edge), synchronous active-low reset
//   coin_1, coin_2  : one-cycle coin pulses (1 and 2 units)
//   sel_valid/select: selection pulse; select 0..2 item, 3 cancel
//   disp_ack        : dispenser finished
//   disp_req/disp_item : dispense request held until disp_ack, item index
//   change_pulse    : one pulse per unit returned
//   coin_reject, sel_deny : one-cycle refusal pulses
//   credit, busy    : current credit; high in DISPENSE or CHANGE
// Optional: define VEND_TIMEOUT_EN to refund credit after TIMEOUT_CYC quiet
// cycles in COLLECT.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned MAX_CREDIT  = 9,
  parameter int unsigned PRICE0      = 3,
  parameter int unsigned PRICE1      = 4,
  parameter int unsigned PRICE2      = 5,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_1,
  input  logic                coin_2,
  input  logic                sel_valid,
  input  logic [1:0]          select,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic [1:0]          disp_item,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                sel_deny,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          item_q, item_d;
  logic                disp_req_q, busy_q;
  logic                reject_q, reject_d;
  logic                deny_q, deny_d;

  logic [1:0]          coin_val;
  logic                coin_any;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W:0]   price;
  logic                pace_start, pace_pulse, pace_done;
  logic                tmo_hit;

  // {coin_2, coin_1} is exactly 2*coin_2 + coin_1.
  assign coin_val = {coin_2, coin_1};
  assign coin_any = coin_1 | coin_2;
  // One extra bit so the MAX_CREDIT compare cannot be fooled by wrap-around.
  assign sum      = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
  assign price    = (CREDIT_W+1)'(item_price(select, PRICE0, PRICE1, PRICE2));

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    reject_d = 1'b0;
    deny_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid && select != SEL_CANCEL) deny_d = 1'b1;
        if (coin_any) begin
          if (sum <= MAX_C) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (sel_valid && select == SEL_CANCEL) begin
          state_d  = CHANGE;
          reject_d = coin_any;
        end else if (sel_valid && {1'b0, credit_q} >= price) begin
          credit_d = credit_q - price[CREDIT_W-1:0];
          item_d   = select;
          state_d  = DISPENSE;
          reject_d = coin_any;
        end else begin
          // A denied selection does not block a coin arriving alongside it.
          if (sel_valid) deny_d = 1'b1;
          if (coin_any) begin
            if (sum <= MAX_C) credit_d = sum[CREDIT_W-1:0];
            else              reject_d = 1'b1;
          end else if (!sel_valid && tmo_hit) begin
            state_d = CHANGE;
          end
        end
      end
      DISPENSE: begin
        reject_d = coin_any;
        if (disp_ack) state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = coin_any;
        if (pace_pulse) credit_d = credit_q - CREDIT_W'(1);
        if (pace_done)  state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The pacer is loaded with the credit held at the moment CHANGE is entered.
  assign pace_start = (state_d == CHANGE) && (state_q != CHANGE);

  vend_change_pacer #(
    .CNT_W (CREDIT_W)
  ) u_pacer (
    .clk     (clk),
    .reset   (reset),
    .start_i (pace_start),
    .count_i (credit_d),
    .pulse_o (pace_pulse),
    .done_o  (pace_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      item_q     <= 2'd0;
      disp_req_q <= 1'b0;
      busy_q     <= 1'b0;
      reject_q   <= 1'b0;
      deny_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      item_q     <= item_d;
      // Decoded from the next state so the outputs line up with the state.
      disp_req_q <= (state_d == DISPENSE);
      busy_q     <= (state_d inside {DISPENSE, CHANGE});
      reject_q   <= reject_d;
      deny_q     <= deny_d;
    end
  end

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;

  // The TIMEOUT_CYC-th consecutive quiet COLLECT cycle triggers the refund.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (state_q != COLLECT || coin_any || sel_valid || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign disp_req     = disp_req_q;
  assign disp_item    = item_q;
  assign change_pulse = pace_pulse;
  assign coin_reject  = reject_q;
  assign sel_deny     = deny_q;
  assign credit       = credit_q;
  assign busy         = busy_q;

endmodule
